// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM feed path.
//   feed_state_e : skew feeder control states
//   ZeroVec      : zero constant, sliced to the element width where a zero element is needed
package gemm_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFeed  = 2'd1,
        StDrain = 2'd2
    } feed_state_e;

    // Wide enough for any realistic element width; users take the low DATA_WIDTH bits.
    localparam int unsigned ZeroWidth = 1024;
    localparam logic [ZeroWidth-1:0] ZeroVec = '0;

endpackage

// File: rtl/skew_feeder_if.sv
// Tile/stream interface of the skew feeder.
//   start, len        : tile request (len vectors), from the master
//   in_valid, in_data : unskewed row vector stream, from the master
//   in_ready          : feeder accepts a vector this cycle
//   out_data          : skewed vector towards the array
//   out_valid         : out_data updated on the previous edge
//   busy, done        : tile in progress / one-cycle completion pulse
interface skew_feeder_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM        = 4,
    parameter int unsigned MAX_LEN    = 256
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    logic                             start;
    logic [LW-1:0]                    len;
    logic                             in_valid;
    logic                             in_ready;
    logic [NUM-1:0][DATA_WIDTH-1:0]   in_data;
    logic [NUM-1:0][DATA_WIDTH-1:0]   out_data;
    logic                             out_valid;
    logic                             busy;
    logic                             done;

    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, out_data, out_valid, busy, done
    );

    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, out_data, out_valid, busy, done
    );

endinterface

// File: rtl/skew_delay_line.sv
// One lane of the skew: a DEPTH-stage shift register that moves only when enabled.
//   clk, rst  : clock, synchronous active-high reset
//   enable    : shift one stage
//   clear     : zero every stage (start of a tile)
//   data_in   : element entering stage 0
//   data_out  : element leaving the last stage
module skew_delay_line #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else if (enable) begin
            stage_q[0] <= data_in;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/skew_feeder.sv
// Skews row vectors for a systolic array: lane i is delayed by i+1 advances, so element i
// of vector n appears on out_data[i] after advance n+i. A tile of len vectors takes
// len+NUM-1 advances: len accepted vectors, then NUM-1 drain advances of zeros.
//   clk, rst : clock, synchronous active-high reset
//   bus      : skew_feeder_if slave (start/len, in_* stream, out_*, busy, done)
module skew_feeder
    import gemm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM        = 4,
    parameter int unsigned MAX_LEN    = 256
) (
    input  logic          clk,
    input  logic          rst,
    skew_feeder_if.slave  bus
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned CW = $clog2(NUM);
    localparam logic [CW-1:0] DrainLast = CW'(NUM - 2);

    feed_state_e   state_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] cnt_q;
    logic [CW-1:0] drain_q;
    logic          out_valid_q;
    logic          done_q;

    logic                           advance;
    logic                           clear;
    logic [NUM-1:0][DATA_WIDTH-1:0] lane_in;
    logic [NUM-1:0][DATA_WIDTH-1:0] lane_out;

    assign bus.in_ready = (state_q == StFeed);
    assign advance      = (bus.in_valid && bus.in_ready) || (state_q == StDrain);
    // Lines start every tile from zero so the leading edge of the skew is clean.
    assign clear        = (state_q == StIdle) && bus.start && (bus.len != '0);

    // Drain pushes zeros; in FEED the lanes only move on an accepted vector.
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            lane_in[i] = (state_q == StFeed) ? bus.in_data[i] : ZeroVec[DATA_WIDTH-1:0];
        end
    end

    for (genvar g = 0; g < NUM; g++) begin : g_lane
        skew_delay_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (g + 1)
        ) u_line (
            .clk      (clk),
            .rst      (rst),
            .enable   (advance),
            .clear    (clear),
            .data_in  (lane_in[g]),
            .data_out (lane_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= advance;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            state_q <= StFeed;
                            len_q   <= bus.len;
                            cnt_q   <= '0;
                        end else begin
                            // Empty tile completes immediately.
                            done_q <= 1'b1;
                        end
                    end
                end
                StFeed: begin
                    if (advance) begin
                        if (cnt_q + LW'(1) == len_q) begin
                            state_q <= StDrain;
                            cnt_q   <= '0;
                            drain_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + LW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (drain_q == DrainLast) begin
                        // Lines up with out_valid of the last drain advance.
                        state_q <= StIdle;
                        drain_q <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.out_data  = lane_out;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_skew_feeder.sv
// Self-checking bench for skew_feeder: a directed table, hand-written corner sequences and
// random tiles checked against a model of the skewed output sequence.
module tb_skew_feeder;

    localparam int unsigned DW  = 32;
    localparam int unsigned NUM = 4;
    localparam int unsigned ML  = 16;
    localparam int unsigned LW  = $clog2(ML + 1);
    localparam int unsigned VW  = DW * NUM;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    skew_feeder_if #(.DATA_WIDTH(DW), .NUM(NUM), .MAX_LEN(ML)) bus ();

    skew_feeder #(.DATA_WIDTH(DW), .NUM(NUM), .MAX_LEN(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] vec [ML][NUM];
    int            stall_before [ML];

    typedef struct {
        logic          start;
        int            len;
        logic          in_valid;
        logic [VW-1:0] in_data;
        logic          e_valid;
        logic [VW-1:0] e_data;
        logic          e_done;
        logic          e_ready;
        logic          e_busy;
    } row_t;

    row_t tbl [13];

    task automatic chkv(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane 0 holds element a.
    function automatic logic [VW-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    endfunction

    function automatic logic [VW-1:0] pack_vec(input int k);
        logic [VW-1:0] r;
        for (int i = 0; i < NUM; i++) r[i*DW +: DW] = vec[k][i];
        return r;
    endfunction

    // Output after advance n of a tile of L vectors: lane i carries element i of vector n-i.
    function automatic logic [VW-1:0] expected(input int n, input int L);
        logic [VW-1:0] r = '0;
        for (int i = 0; i < NUM; i++) begin
            if (n - i >= 0 && n - i < L) r[i*DW +: DW] = vec[n-i][i];
        end
        return r;
    endfunction

    task automatic observe(input int L, inout int n, inout logic [VW-1:0] mo,
                           input logic want_ready, input logic want_valid);
        int total = L + NUM - 1;
        chk1("in_ready", bus.in_ready, want_ready);
        chk1("out_valid", bus.out_valid, want_valid);
        if (want_valid) begin
            mo = expected(n, L);
            n++;
            chkv("out_data", bus.out_data, mo);
        end else begin
            chkv("hold", bus.out_data, mo);
        end
        chk1("done", bus.done, want_valid && (n == total));
        chk1("busy", bus.busy, n != total);
    endtask

    // Runs one tile from IDLE using vec/stall_before; noise drives ignored start/in_valid.
    task automatic run_tile(input int L, input bit noise);
        int            n  = 0;
        logic [VW-1:0] mo = '0;
        bus.start = 1'b1;
        bus.len   = LW'(L);
        step();
        bus.start = noise;
        bus.len   = LW'(5);
        observe(L, n, mo, 1'b1, 1'b0);
        for (int k = 0; k < L; k++) begin
            for (int s = 0; s < stall_before[k]; s++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
                step();
                observe(L, n, mo, 1'b1, 1'b0);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = pack_vec(k);
            step();
            observe(L, n, mo, k < L - 1, 1'b1);
        end
        for (int d = 0; d < NUM - 1; d++) begin
            bus.in_valid = noise ? 1'($urandom) : 1'b0;
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
            observe(L, n, mo, 1'b0, 1'b1);
        end
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        step();
        observe(L, n, mo, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int k = 0; k < ML; k++) stall_before[k] = 0;
        repeat (3) step();
        chk1("rst_valid", bus.out_valid, 1'b0);
        chkv("rst_data", bus.out_data, '0);
        chk1("rst_done", bus.done, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        step();

        // Basic 3-vector tile, then a 1-vector tile started in the done cycle.
        tbl[0]  = '{1'b1, 3, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 0, 1'b1, pk(1, 2, 3, 4), 1'b1, pk(1, 0, 0, 0), 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 0, 1'b1, pk(5, 6, 7, 8), 1'b1, pk(5, 2, 0, 0), 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 0, 1'b1, pk(9, 10, 11, 12), 1'b1, pk(9, 6, 3, 0), 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 0, 1'b0, '0, 1'b1, pk(0, 10, 7, 4), 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 0, 1'b0, '0, 1'b1, pk(0, 0, 11, 8), 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 0, 1'b0, '0, 1'b1, pk(0, 0, 0, 12), 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 0, 1'b1, pk(13, 14, 15, 16), 1'b1, pk(13, 0, 0, 0), 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 0, 1'b0, '0, 1'b1, pk(0, 14, 0, 0), 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 0, 1'b0, '0, 1'b1, pk(0, 0, 15, 0), 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 0, 1'b0, '0, 1'b1, pk(0, 0, 0, 16), 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 0, 1'b0, '0, 1'b0, pk(0, 0, 0, 16), 1'b0, 1'b0, 1'b0};
        for (int r = 0; r < 13; r++) begin
            bus.start    = tbl[r].start;
            bus.len      = LW'(tbl[r].len);
            bus.in_valid = tbl[r].in_valid;
            bus.in_data  = tbl[r].in_data;
            step();
            chk1($sformatf("tbl%0d_valid", r), bus.out_valid, tbl[r].e_valid);
            chkv($sformatf("tbl%0d_data", r), bus.out_data, tbl[r].e_data);
            chk1($sformatf("tbl%0d_done", r), bus.done, tbl[r].e_done);
            chk1($sformatf("tbl%0d_ready", r), bus.in_ready, tbl[r].e_ready);
            chk1($sformatf("tbl%0d_busy", r), bus.busy, tbl[r].e_busy);
        end

        // Same tile with a two-cycle stall after the first vector.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NUM; i++) vec[k][i] = DW'(k * NUM + i + 1);
        end
        stall_before[1] = 2;
        run_tile(3, 1'b0);
        stall_before[1] = 0;

        // Empty tile: done one cycle later, never busy.
        bus.start = 1'b1;
        bus.len   = '0;
        step();
        bus.start = 1'b0;
        chk1("len0_done", bus.done, 1'b1);
        chk1("len0_busy", bus.busy, 1'b0);
        chk1("len0_ready", bus.in_ready, 1'b0);
        chk1("len0_valid", bus.out_valid, 1'b0);
        step();
        chk1("len0_done_end", bus.done, 1'b0);
        chk1("len0_busy_end", bus.busy, 1'b0);

        // Start (len=5) held during the tile is ignored.
        run_tile(3, 1'b1);

        // Reset in the second drain cycle aborts the tile.
        bus.start = 1'b1;
        bus.len   = LW'(3);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pack_vec(k);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk1("abort_valid", bus.out_valid, 1'b0);
        chkv("abort_data", bus.out_data, '0);
        chk1("abort_done", bus.done, 1'b0);
        chk1("abort_busy", bus.busy, 1'b0);
        chk1("abort_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        step();
        chk1("abort_no_done", bus.done, 1'b0);
        for (int i = 0; i < NUM; i++) vec[0][i] = DW'(7);
        run_tile(1, 1'b0);

        // Random tiles.
        for (int t = 0; t < 30; t++) begin
            int L = $urandom_range(1, ML);
            for (int k = 0; k < ML; k++) begin
                for (int i = 0; i < NUM; i++) vec[k][i] = $urandom;
                stall_before[k] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2);
            end
            run_tile(L, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
